// File: rtl/instruction_decode_queue_pkg.sv
// Shared decode types, RV32I opcode constants and decode helpers for the decode queue.
// The per-entry illegal flag is produced only when JZJCOREF_ILLEGAL_DETECT_EN is defined.
package JZJCoreFTypes;

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} ImmediateFormat;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpReg     = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } DecodedAddresses;

    typedef struct packed {
        DecodedAddresses addresses;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        ImmediateFormat  format;
        logic [31:0]     immediate;
        logic            illegal;
        logic [31:0]     pc;
    } DecodedInstruction;

    // Stored form of a queue entry; the illegal flag lives in its own array when enabled.
    typedef struct packed {
        DecodedAddresses addresses;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        ImmediateFormat  format;
        logic [31:0]     immediate;
        logic [31:0]     pc;
    } QueueEntry;

    function automatic ImmediateFormat select_format(input logic [6:0] opcode);
        ImmediateFormat fmt;
        fmt = FmtR;
        case (opcode)
            OpLui, OpAuipc:                  fmt = FmtU;
            OpJal:                           fmt = FmtJ;
            OpJalr, OpLoad, OpImm, OpSystem: fmt = FmtI;
            OpStore:                         fmt = FmtS;
            OpBranch:                        fmt = FmtB;
            default:                         fmt = FmtR;
        endcase
        return fmt;
    endfunction

    function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
        logic legal;
        legal = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpImm, OpSystem,
            OpStore, OpBranch, OpReg, OpMiscMem: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instruction_field_extractor.sv
// Purely combinational RV32I field extraction and immediate generation for one instruction.
// Illegal-opcode flagging is enabled by JZJCOREF_ILLEGAL_DETECT_EN.
module instruction_field_extractor
    import JZJCoreFTypes::*;
(
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc,
    output DecodedInstruction decoded
);

    ImmediateFormat imm_format;

    always_comb begin
        imm_format = select_format(instruction[6:0]);

        decoded               = '0;
        decoded.addresses.rs1 = instruction[19:15];
        decoded.addresses.rs2 = instruction[24:20];
        decoded.addresses.rd  = instruction[11:7];
        decoded.opcode        = instruction[6:0];
        decoded.funct3        = instruction[14:12];
        decoded.funct7        = instruction[31:25];
        decoded.format        = imm_format;
        decoded.pc            = pc;

        case (imm_format)
            FmtI: decoded.immediate = {{20{instruction[31]}}, instruction[31:20]};
            FmtS: decoded.immediate = {{20{instruction[31]}}, instruction[31:25],
                                       instruction[11:7]};
            FmtB: decoded.immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                                       instruction[30:25], instruction[11:8], 1'b0};
            FmtU: decoded.immediate = {instruction[31:12], 12'h000};
            FmtJ: decoded.immediate = {{11{instruction[31]}}, instruction[31],
                                       instruction[19:12], instruction[20],
                                       instruction[30:21], 1'b0};
            default: decoded.immediate = 32'h0;
        endcase

`ifdef JZJCOREF_ILLEGAL_DETECT_EN
        decoded.illegal = !is_rv32i_opcode(instruction[6:0]);
`else
        decoded.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/instruction_decode_queue.sv
// FIFO of pre-decoded RV32I instructions; decode happens on the write path so outputs are raw
// storage. Per-entry illegal-opcode flag is stored only with JZJCOREF_ILLEGAL_DETECT_EN defined.
module instruction_decode_queue
    import JZJCoreFTypes::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output DecodedAddresses            out_addresses,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output ImmediateFormat             out_format,
    output logic [31:0]                out_immediate,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned CountWidth = $clog2(DEPTH + 1);

    DecodedInstruction     write_decoded;
    QueueEntry             entries [DEPTH];
    QueueEntry             head;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  push, pop;

    instruction_field_extractor u_extractor (
        .instruction (in_instruction),
        .pc          (in_pc),
        .decoded     (write_decoded)
    );

    // A full queue refuses a push even when the head is popped in the same cycle.
    assign in_ready  = reset && (count_q < CountWidth'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CountWidth'(1);
                2'b01:   count_d = count_q - CountWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            entries[wr_ptr_q].addresses <= write_decoded.addresses;
            entries[wr_ptr_q].opcode    <= write_decoded.opcode;
            entries[wr_ptr_q].funct3    <= write_decoded.funct3;
            entries[wr_ptr_q].funct7    <= write_decoded.funct7;
            entries[wr_ptr_q].format    <= write_decoded.format;
            entries[wr_ptr_q].immediate <= write_decoded.immediate;
            entries[wr_ptr_q].pc        <= write_decoded.pc;
        end
    end

    assign head          = entries[rd_ptr_q];
    assign out_pc        = head.pc;
    assign out_addresses = head.addresses;
    assign out_opcode    = head.opcode;
    assign out_funct3    = head.funct3;
    assign out_funct7    = head.funct7;
    assign out_format    = head.format;
    assign out_immediate = head.immediate;
    assign count         = count_q;

`ifdef JZJCOREF_ILLEGAL_DETECT_EN
    logic [DEPTH-1:0] illegal_q;

    always_ff @(posedge clock) begin
        if (push && !flush) illegal_q[wr_ptr_q] <= write_decoded.illegal;
    end

    assign out_illegal = illegal_q[rd_ptr_q];
`else
    logic unused_illegal;

    assign unused_illegal = write_decoded.illegal;
    assign out_illegal    = 1'b0;
`endif

endmodule

// File: doc/instruction_decode_queue.md
INSTRUCTION_DECODE_QUEUE -- requirements
Module: instruction_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-instruction entries; power of two, minimum 2.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 flush  input  1  discards all queued entries.
REQ-005 in_valid  input  1  in_instruction/in_pc valid.
REQ-006 in_ready  output  1  queue can accept an instruction this cycle.
REQ-007 in_instruction  input  32  raw RV32I instruction word.
REQ-008 in_pc  input  32  instruction address.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer takes head entry this cycle.
REQ-011 out_pc  output  32  head entry PC.
REQ-012 out_addresses  output  DecodedAddresses  rs1/rs2/rd of head entry.
REQ-013 out_opcode / out_funct3 / out_funct7  output  7/3/7  head entry fields.
REQ-014 out_format  output  ImmediateFormat  format selected for head entry.
REQ-015 out_immediate  output  32  sign-extended immediate of out_format.
REQ-016 out_illegal  output  1  head entry is not a legal RV32I opcode.
REQ-017 count  output  $clog2(DEPTH+1)  occupied entries.

Function
- REQ-018 Decode SHALL occur on write: each entry stores the fully decoded fields, so every out_* signal comes directly from storage with no decode logic on the output path.
- REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- REQ-020 in_ready SHALL equal (count < DEPTH) && reset deasserted; a full queue refuses a push even if a pop occurs in the same cycle.
- REQ-021 out_valid SHALL equal (count != 0).
- REQ-022 Latency: an instruction pushed at edge N SHALL be visible on out_* with out_valid high after edge N when the queue was empty; there is no same-cycle bypass.
- REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
- REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-025 Field extraction: rs1 = [19:15], rs2 = [24:20], rd = [11:7], opcode = [6:0], funct3 = [14:12], funct7 = [31:25].
- REQ-026 Format select by opcode:
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 1100111, 0000011, 0010011, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - all others -> R
- REQ-027 Immediate encodings, all sign-extended from bit 31:
  - I = [31:20]
  - S = {[31:25], [11:7]}
  - B = {[31], [7], [30:25], [11:8], 0}
  - U = {[31:12], 12'h000}
  - J = {[31], [19:12], [20], [30:21], 0}
  - R = 32'h0
- REQ-028 flush SHALL, at the next edge, set count to 0, reset both pointers and drop any concurrent push; flush has priority over push and pop.
- REQ-029 Output fields SHALL hold stable while out_valid && !out_ready.

Reset
- REQ-030 With reset low at an edge: count = 0, pointers = 0, out_valid = 0; in_ready SHALL be 0 while reset is low.
- REQ-031 Reset asserted mid-operation SHALL discard all entries, with the same result as flush; storage contents need not be cleared.
- REQ-032 After reset deasserts, in_ready = 1 in the first cycle.

Configuration
- REQ-033 Macro JZJCOREF_ILLEGAL_DETECT_EN.
  - Defined: out_illegal = 1 when opcode[1:0] != 2'b11 or the opcode is not one of the eleven RV32I opcodes (those in REQ-026 plus 0110011 and 0001111). The flag is stored per entry.
  - Undefined: out_illegal is tied to 0 and no per-entry illegal bit is stored.

Structure
- REQ-034 ImmediateFormat enum (R, I, S, B, U, J), the opcode constants, and a DecodedInstruction struct (addresses, opcode, funct3, funct7, format, immediate, illegal, pc) SHALL live in JZJCoreFTypes, alongside DecodedAddresses.
- REQ-035 Combinational decode SHALL be the sub-module instruction_field_extractor (instruction in, DecodedInstruction out); the queue instantiates it on the write path.

Verification
- REQ-036 Push 0xFFF10093 into an empty queue -> next cycle: out_valid = 1, rs1 = 2, rd = 1, format I, immediate 0xFFFFFFFF, count = 1.
- REQ-037 Push 0xFFDFF06F (JAL x0, -4) then 0x00512423 (SW x5, 8(x2)); pop both -> first J with immediate 0xFFFFFFFC, then S with rs1 = 2, rs2 = 5, immediate 0x00000008, in order.
- REQ-038 DEPTH = 4, out_ready = 0, push 5 times -> in_ready = 0 after the 4th push, 5th word not accepted, count = 4; pushing and popping in the same cycle while full still yields count = 3.
- REQ-039 count = 2, assert push, pop and flush in one cycle -> next cycle count = 0, out_valid = 0, pushed word absent.
- REQ-040 With the macro defined, push 0x00000000 -> out_illegal = 1, format R, immediate 0; push 0x123451B7 -> out_illegal = 0, format U, immediate 0x12345000, rd = 3.
- REQ-041 Pull reset low with 3 entries queued -> count = 0 and out_valid = 0 at the next edge, in_ready = 0 while reset is low, in_ready = 1 the cycle after release.
